// File: rtl/keycode_event_ctrl.sv
// Multi-key keyboard event controller: debounced press/release,
// held level, auto-repeat and sticky latched flags per table key.
module keycode_event_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int KEYCODE_W       = 8,
    parameter logic [NUM_KEYS*KEYCODE_W-1:0] KEY_TABLE =
        {8'h2C, 8'h16, 8'h1A, 8'h28},
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [KEYCODE_W-1:0] keycode,
    input  logic [NUM_KEYS-1:0]  clear,
    output logic [NUM_KEYS-1:0]  press_pulse,
    output logic [NUM_KEYS-1:0]  release_pulse,
    output logic [NUM_KEYS-1:0]  repeat_pulse,
    output logic [NUM_KEYS-1:0]  held,
    output logic [NUM_KEYS-1:0]  latched,
    output logic                 any_latched
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                             DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ?
                             MAX_DR : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST =
        CW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    localparam bit            REP_EN  = (REPEAT_DELAY > 0);
    localparam bit            DB_ONE  = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        REPEAT
    } state_t;

    state_t              state [NUM_KEYS];
    logic [CW-1:0]       cnt   [NUM_KEYS];
    logic [KEYCODE_W-1:0] code [NUM_KEYS];

    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] press_set;
    logic [NUM_KEYS-1:0] latched_nxt;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_code
        assign code[g] = KEY_TABLE[g*KEYCODE_W +: KEYCODE_W];
    end

    // A zero table entry never matches, so that channel stays idle forever.
    always_comb begin
        match       = '0;
        press_set   = '0;
        latched_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = (keycode == code[i]) && (code[i] != '0);
            press_set[i] = match[i] &&
                (((state[i] == IDLE) && DB_ONE) ||
                 ((state[i] == DEBOUNCE) && (cnt[i] == DB_LAST)));
            latched_nxt[i] = press_set[i] | (latched[i] & ~clear[i]);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            press_pulse   <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            held          <= '0;
            latched       <= '0;
            any_latched   <= 1'b0;
        end else begin
            latched     <= latched_nxt;
            any_latched <= |latched_nxt;
            for (int i = 0; i < NUM_KEYS; i++) begin
                press_pulse[i]   <= 1'b0;
                release_pulse[i] <= 1'b0;
                repeat_pulse[i]  <= 1'b0;
                unique case (state[i])
                    IDLE: begin
                        if (press_set[i]) begin
                            state[i]       <= HELD;
                            cnt[i]         <= '0;
                            press_pulse[i] <= 1'b1;
                            held[i]        <= 1'b1;
                        end else if (match[i]) begin
                            state[i] <= DEBOUNCE;
                            cnt[i]   <= CW'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (!match[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (press_set[i]) begin
                            state[i]       <= HELD;
                            cnt[i]         <= '0;
                            press_pulse[i] <= 1'b1;
                            held[i]        <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!match[i]) begin
                            state[i]         <= IDLE;
                            cnt[i]           <= '0;
                            release_pulse[i] <= 1'b1;
                            held[i]          <= 1'b0;
                        end else if (REP_EN) begin
                            if (cnt[i] == RD_LAST) begin
                                state[i]        <= REPEAT;
                                cnt[i]          <= '0;
                                repeat_pulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CW'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        // Counter wraps every period, so holding never overflows.
                        if (!match[i]) begin
                            state[i]         <= IDLE;
                            cnt[i]           <= '0;
                            release_pulse[i] <= 1'b1;
                            held[i]          <= 1'b0;
                        end else if (cnt[i] == RP_LAST) begin
                            cnt[i]          <= '0;
                            repeat_pulse[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// Directed bench for keycode_event_ctrl: default table plus a
// variant with a disabled channel and auto-repeat turned off.
module tb_keycode_event_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [7:0] keycode2;
    logic [3:0] clear;
    logic [3:0] clear2;

    logic [3:0] pp, rp, rr, hd, lt;
    logic       al;
    logic [3:0] pp2, rp2, rr2, hd2, lt2;
    logic       al2;

    int n_assert = 0;
    int n_fail   = 0;
    int reps;

    keycode_event_ctrl u_dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .keycode       (keycode),
        .clear         (clear),
        .press_pulse   (pp),
        .release_pulse (rp),
        .repeat_pulse  (rr),
        .held          (hd),
        .latched       (lt),
        .any_latched   (al)
    );

    keycode_event_ctrl #(
        .KEY_TABLE    ({8'h00, 8'h16, 8'h1A, 8'h28}),
        .REPEAT_DELAY (0)
    ) u_dut2 (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .keycode       (keycode2),
        .clear         (clear2),
        .press_pulse   (pp2),
        .release_pulse (rp2),
        .repeat_pulse  (rr2),
        .held          (hd2),
        .latched       (lt2),
        .any_latched   (al2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n  = 1'b0;
        keycode  = 8'h00;
        keycode2 = 8'h00;
        clear    = 4'h0;
        clear2   = 4'h0;
        #3;
        chk("reset_dut1", {11'd0, pp, rp, rr, hd, lt, al}, 32'd0);
        chk("reset_dut2", {11'd0, pp2, rp2, rr2, hd2, lt2, al2}, 32'd0);
        #9 Reset_n = 1'b1;

        // Short press: three matching edges never confirm.
        keycode = 8'h28;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("short_pp", {28'd0, pp}, 32'd0);
        end
        keycode = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("short_all", {11'd0, pp, rp, rr, hd, lt, al}, 32'd0);
        end

        // Long press on ch0 through auto-repeat, then release.
        keycode  = 8'h28;
        keycode2 = 8'h28;
        reps = 0;
        for (int k = 0; k <= 30; k++) begin
            if (k == 30) begin
                keycode  = 8'h00;
                keycode2 = 8'h00;
            end
            tick();
            if (rr[0]) reps++;
            chk("long_pp0", {31'd0, pp[0]}, {31'd0, k == 3});
            chk("long_hd0", {31'd0, hd[0]}, {31'd0, k >= 3 && k <= 29});
            chk("long_rr0", {31'd0, rr[0]},
                {31'd0, k == 19 || k == 23 || k == 27});
            chk("long_rp0", {31'd0, rp[0]}, {31'd0, k == 30});
            chk("long_other", {20'd0, pp[3:1], rp[3:1], rr[3:1], hd[3:1]},
                32'd0);
            chk("norep_rr2", {28'd0, rr2}, 32'd0);
            chk("norep_pp2", {31'd0, pp2[0]}, {31'd0, k == 3});
            chk("norep_rp2", {31'd0, rp2[0]}, {31'd0, k == 30});
        end
        chk("long_reps", reps, 32'd3);
        chk("long_lt", {28'd0, lt}, 32'd1);
        chk("long_al", {31'd0, al}, 32'd1);

        // Direct switch from Enter to W.
        keycode = 8'h28;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sw_deb_pp0", {31'd0, pp[0]}, 32'd0);
        end
        tick();
        chk("sw_pp0", {31'd0, pp[0]}, 32'd1);
        tick();
        chk("sw_hd0", {31'd0, hd[0]}, 32'd1);
        keycode = 8'h1A;
        tick();
        chk("sw_rp0", {31'd0, rp[0]}, 32'd1);
        chk("sw_hd0_low", {31'd0, hd[0]}, 32'd0);
        chk("sw_pp1_early", {31'd0, pp[1]}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("sw_pp1_deb", {31'd0, pp[1]}, 32'd0);
            chk("sw_quiet", {22'd0, pp[3:2], rp[3:2], rr[3:2], hd[3:2],
                lt[3:2]}, 32'd0);
        end
        tick();
        chk("sw_pp1", {31'd0, pp[1]}, 32'd1);
        chk("sw_hd1", {31'd0, hd[1]}, 32'd1);
        chk("sw_lt", {28'd0, lt}, 32'd3);
        chk("sw_quiet_end", {22'd0, pp[3:2], rp[3:2], rr[3:2], hd[3:2],
            lt[3:2]}, 32'd0);
        clear = 4'b0010;
        tick();
        clear = 4'b0000;
        chk("clr1_lt", {28'd0, lt}, 32'd1);
        chk("clr1_al", {31'd0, al}, 32'd1);

        // Clear on the press edge loses to the press.
        keycode = 8'h00;
        tick();
        chk("rel1_rp", {28'd0, rp}, 32'd2);
        keycode = 8'h28;
        for (int k = 0; k < 3; k++) tick();
        clear = 4'b0001;
        tick();
        chk("setwin_pp0", {31'd0, pp[0]}, 32'd1);
        chk("setwin_lt", {28'd0, lt}, 32'd1);
        tick();
        clear = 4'b0000;
        chk("clr0_lt", {28'd0, lt}, 32'd0);
        chk("clr0_al", {31'd0, al}, 32'd0);

        // Hold into REPEAT then reset asynchronously.
        reps = 0;
        for (int k = 5; k <= 21; k++) begin
            tick();
            if (rr[0]) reps++;
            chk("rep_rr0", {31'd0, rr[0]}, {31'd0, k == 19});
        end
        chk("rep_count", reps, 32'd1);
        chk("rep_hd0", {31'd0, hd[0]}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_dut1", {11'd0, pp, rp, rr, hd, lt, al}, 32'd0);
        chk("async_dut2", {11'd0, pp2, rp2, rr2, hd2, lt2, al2}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_pp0", {31'd0, pp[0]}, 32'd0);
            chk("post_rst_hd0", {31'd0, hd[0]}, 32'd0);
        end
        tick();
        chk("post_rst_press", {31'd0, pp[0]}, 32'd1);

        // Disabled channel and no-repeat variant.
        keycode2 = 8'h00;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("dis_idle", {11'd0, pp2, rp2, rr2, hd2, lt2, al2}, 32'd0);
        end
        keycode2 = 8'h2C;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("dis_space", {11'd0, pp2, rp2, rr2, hd2, lt2, al2}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
